// File: rtl/aes_cone_result_packer.sv
// Packs a serial stream of 1-bit AES cone results LSB-first into WORD_W-bit words
// and presents them on a valid/ready output with bit count and parity.
module aes_cone_result_packer #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_parity,
  output logic [15:0]       words_out
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]    acc_cnt_reg, acc_cnt_next;
  logic                out_valid_reg, out_valid_next;
  logic [WORD_W-1:0]   out_data_reg, out_data_next;
  logic [CNT_W-1:0]    out_count_reg, out_count_next;
  logic                out_parity_reg, out_parity_next;
  logic [15:0]         words_out_reg, words_out_next;

  logic                accept, fire, out_free, completes;
  logic [WORD_W-1:0]   word_with_bit;
  logic [CNT_W-1:0]    cnt_inc;

  assign in_ready   = (state_reg == FILL);
  assign accept     = in_valid && in_ready;
  assign fire       = out_valid_reg && out_ready;
  assign out_free   = !out_valid_reg || out_ready;
  assign cnt_inc    = acc_cnt_reg + CNT_W'(1);
  assign completes  = accept && ((cnt_inc == CNT_W'(WORD_W)) || in_last);

  // Accumulator with the incoming bit dropped into slot acc_cnt; slots above
  // stay zero because acc is cleared whenever a word leaves it.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_slot
      assign word_with_bit[gi] = (acc_cnt_reg == CNT_W'(gi)) ? in_bit : acc_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    acc_cnt_next    = acc_cnt_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_count_next  = out_count_reg;
    out_parity_next = out_parity_reg;
    words_out_next  = words_out_reg + {15'd0, fire};

    if (fire) out_valid_next = 1'b0;

    case (state_reg)
      FILL: begin
        if (accept) begin
          if (completes && out_free) begin
            out_valid_next  = 1'b1;
            out_data_next   = word_with_bit;
            out_count_next  = cnt_inc;
            out_parity_next = ^word_with_bit;
            acc_next        = '0;
            acc_cnt_next    = '0;
          end else begin
            acc_next     = word_with_bit;
            acc_cnt_next = cnt_inc;
            if (completes) state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_valid_next  = 1'b1;
          out_data_next   = acc_reg;
          out_count_next  = acc_cnt_reg;
          out_parity_next = ^acc_reg;
          acc_next        = '0;
          acc_cnt_next    = '0;
          state_next      = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      acc_reg        <= '0;
      acc_cnt_reg    <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_count_reg  <= '0;
      out_parity_reg <= 1'b0;
      words_out_reg  <= '0;
    end else if (soft_clr) begin
      state_reg      <= FILL;
      acc_reg        <= '0;
      acc_cnt_reg    <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_count_reg  <= '0;
      out_parity_reg <= 1'b0;
      words_out_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      acc_cnt_reg    <= acc_cnt_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_count_reg  <= out_count_next;
      out_parity_reg <= out_parity_next;
      words_out_reg  <= words_out_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_count  = out_count_reg;
  assign out_parity = out_parity_reg;
  assign words_out  = words_out_reg;

endmodule

// File: tb/tb_aes_cone_result_packer.sv
// Directed bench for aes_cone_result_packer (WORD_W=8): reset, partial words,
// backpressure/HOLD, back-to-back streaming, soft_clr and words_out wrap.
module tb_aes_cone_result_packer;

  logic        clk = 1'b0;
  logic        rst_n, soft_clr, in_valid, in_ready, in_bit, in_last;
  logic        out_valid, out_ready, out_parity;
  logic [7:0]  out_data;
  logic [3:0]  out_count;
  logic [15:0] words_out;

  int tests = 0;
  int fails = 0;

  aes_cone_result_packer #(.WORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_parity(out_parity), .words_out(words_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic last);
    in_valid = 1'b1; in_bit = b; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] b2b [8];
    int vcount;

    rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready",  32'(in_ready),   32'h1);
    chk("rst_out_valid", 32'(out_valid),  32'h0);
    chk("rst_out_data",  32'(out_data),   32'h0);
    chk("rst_out_count", 32'(out_count),  32'h0);
    chk("rst_parity",    32'(out_parity), 32'h0);
    chk("rst_words_out", 32'(words_out),  32'h0);

    // Reset mid-word: 5 ones then asynchronous reset
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      send(pat[i], 1'b0);
      if (i == 6) chk("w4d_not_early", 32'(out_valid), 32'h0);
    end
    chk("w4d_valid",  32'(out_valid),  32'h1);
    chk("w4d_data",   32'(out_data),   32'h4D);
    chk("w4d_count",  32'(out_count),  32'h8);
    chk("w4d_parity", 32'(out_parity), 32'h0);
    tick();
    chk("w4d_drop",   32'(out_valid),  32'h0);
    chk("w4d_hold_data", 32'(out_data), 32'h4D);
    chk("w4d_words",  32'(words_out),  32'h1);

    // Partial word 1,1,1 with in_last
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b1);
    chk("p3_valid",  32'(out_valid),  32'h1);
    chk("p3_data",   32'(out_data),   32'h07);
    chk("p3_count",  32'(out_count),  32'h3);
    chk("p3_parity", 32'(out_parity), 32'h1);
    tick();

    // in_last on the very first bit
    send(1'b1, 1'b1);
    chk("p1_data",  32'(out_data),  32'h01);
    chk("p1_count", 32'(out_count), 32'h1);
    tick();

    // in_last on the 8th bit: normal full word, no empty word after it
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) send(pat[i], i == 7);
    chk("l8_data",   32'(out_data),   32'hA5);
    chk("l8_count",  32'(out_count),  32'h8);
    chk("l8_parity", 32'(out_parity), 32'h0);
    tick();
    tick();
    chk("l8_no_empty", 32'(out_valid), 32'h0);
    chk("l8_words",    32'(words_out), 32'h4);

    // Backpressure: 16 ones with out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 7) chk("bp_first_data", 32'(out_data), 32'hFF);
      if (i < 15) chk("bp_in_ready", 32'(in_ready), 32'h1);
    end
    chk("bp_hold_ready", 32'(in_ready),  32'h0);
    chk("bp_stable",     32'(out_data),  32'hFF);
    in_bit = 1'b0; in_last = 1'b1;
    tick();
    chk("bp_ignored_ready", 32'(in_ready), 32'h0);
    chk("bp_ignored_count", 32'(out_count), 32'h8);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_w1_valid", 32'(out_valid), 32'h1);
    chk("bp_w2_data",  32'(out_data),  32'hFF);
    chk("bp_w2_count", 32'(out_count), 32'h8);
    chk("bp_ready_back", 32'(in_ready), 32'h1);
    chk("bp_words1",   32'(words_out), 32'h5);
    tick();
    out_ready = 1'b0;
    chk("bp_drained",  32'(out_valid), 32'h0);
    chk("bp_words2",   32'(words_out), 32'h6);

    // Back-to-back 64 bits
    b2b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b0;
    vcount = 0;
    for (int i = 0; i < 64; i++) begin
      pat = b2b[i / 8];
      in_bit = pat[i % 8];
      tick();
      chk($sformatf("b2b_ready_%0d", i), 32'(in_ready), 32'h1);
      chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'((i % 8) == 7));
      if (out_valid) begin
        vcount++;
        chk($sformatf("b2b_data_%0d", i / 8), 32'(out_data), 32'(pat));
        chk($sformatf("b2b_par_%0d", i / 8), 32'(out_parity), 32'(^pat));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_vcount", 32'(vcount), 32'd8);
    chk("b2b_words",  32'(words_out), 32'd14);

    // soft_clr while in HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b1);
    chk("sc_in_hold", 32'(in_ready), 32'h0);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    chk("sc_valid", 32'(out_valid), 32'h0);
    chk("sc_ready", 32'(in_ready),  32'h1);
    chk("sc_words", 32'(words_out), 32'h0);
    chk("sc_data",  32'(out_data),  32'h0);
    out_ready = 1'b1;
    tick(); tick();
    chk("sc_no_emit", 32'(out_valid), 32'h0);
    chk("sc_words2",  32'(words_out), 32'h0);

    // words_out wrap: 0xFFFF one-bit words, then one more
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    chk("wrap_ffff", 32'(words_out), 32'hFFFF);
    send(1'b0, 1'b1);
    chk("wrap_last_count", 32'(out_count), 32'h1);
    tick(); tick();
    chk("wrap_zero", 32'(words_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_cone_result_packer.md
Name: aes_cone_result_packer

Overview:
- Downstream stage for the single-bit AES timing-cone outputs (e.g. one n_39-style cone result per cycle).
- Collects a serial stream of 1-bit cone results and packs them LSB-first into WORD_W-bit words.
- Presents each word on a valid/ready output with bit count and parity, for the byte-level capture logic that follows.
- Provides backpressure to the cone launch side when the output path is stalled.

Parameters:
- WORD_W, 8, bits per packed output word; legal range 2..32.
- CNT_W, $clog2(WORD_W+1), width of bit-count fields; derived, not to be overridden.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- soft_clr  input  1  synchronous clear of all state, same reset values as rst_n
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  packer can accept a bit this cycle
- in_bit  input  1  cone result bit
- in_last  input  1  with an accepted bit: close the current word even if partial
- out_valid  output  1  out_data/out_count/out_parity valid
- out_ready  input  1  consumer accepts the word this cycle
- out_data  output  WORD_W  packed word, bit 0 = first accepted bit; unused upper bits are 0
- out_count  output  CNT_W  number of valid bits in out_data, 1..WORD_W
- out_parity  output  1  XOR of out_data[WORD_W-1:0]
- words_out  output  16  count of completed output handshakes, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, asynchronous) and soft_clr (synchronous, priority over every other event):
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_parity=0, words_out=0.
  - Accumulator and its count are cleared; FSM goes to FILL.
  - Reset mid-word discards the partial word.
- Input accept: in_valid && in_ready.
  - Accepted bit is written to acc[acc_cnt]; acc_cnt increments.
  - Word completes when acc_cnt+1 == WORD_W, or when in_last=1 on the accepted bit.
- Output handshake: out_valid && out_ready.
  - Output register is free when out_valid=0 or when the handshake fires this cycle.
- FSM FILL (in_ready=1):
  - Word completes and output register is free: load output register next edge with out_data=completed word (upper bits zero), out_count=bits, out_parity; out_valid=1. acc_cnt returns to 0. Stay in FILL.
  - Latency: the completing bit accepted at edge N gives out_valid=1 after edge N, a 1-cycle latency.
  - Word completes and output register is not free: latch the completed word in acc, go to HOLD.
  - Otherwise remain in FILL.
- FSM HOLD (in_ready=0; input is ignored even if in_valid=1):
  - When the output register becomes free, load the held word and clear acc_cnt. Go to FILL. in_ready=1 on the following cycle.
- Output handshake with no new load: out_valid drops to 0. out_data, out_count and out_parity keep their values.
- Each output handshake increments words_out by 1, mod 2^16.
- in_last on the very first bit gives a 1-bit word: out_count=1.
- in_last on the WORD_W-th bit gives a normal full word; no empty word is emitted.
- in_bit and in_last are ignored when not accepted.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_count and out_parity are held stable.
- No combinational path from in_valid to in_ready.
- No combinational path from out_ready to out_valid.
- in_ready depends only on FSM state.

Test Plan:
- Reset: drive rst_n low mid-word after 5 accepted bits, release, then send 8 bits 1,0,1,1,0,0,1,0 with out_ready=1 -> one word out_data=0x4D, out_count=8, out_parity=0, valid 1 cycle after the 8th bit; no trace of the pre-reset bits.
- Partial word: send 3 bits 1,1,1 with in_last on the 3rd -> out_data=0x07, out_count=3, out_parity=1.
- Backpressure: out_ready=0, stream 16 bits of 1 -> first word 0xFF held stable; in_ready drops after the 16th bit (HOLD). Raise out_ready for 2 cycles -> words 0xFF, 0xFF in order; in_ready returns 1; words_out=2.
- Back-to-back: continuous in_valid=1 and out_ready=1 for 64 bits -> 8 words, no in_ready deassertion, out_valid high on 8 cycles spaced 8 apart.
- soft_clr in HOLD -> out_valid=0, in_ready=1, words_out=0 next cycle; the held word is never emitted.
- Wrap: preload 0xFFFF output handshakes, then 1 more -> words_out=0x0000.
